qpsk_uart_dump_ctrl: RTL and testbench
======================================

Name: qpsk_uart_dump_ctrl

Overview:
- Sequences the readout of stored amplitude/phase-corrected QPSK samples from the output BRAM to the UART byte transmitter once the write phase has finished.
- Port A reads I samples at addresses 0..SAMPLE_NUM-1, and port B reads Q samples at Q_BASE+n.
- Each I/Q pair is packed into 3 bytes and sent over a valid/ready byte interface, preceded by an optional 2-byte frame header.
- Sits between the BRAM write controller (source of wr_over) and the UART TX byte engine.

Parameters:
- SAMPLE_NUM, 10000, number of I/Q pairs to dump
- ADDR_W, 15, BRAM address width
- DATA_W, 12, I/Q sample width; fixed at 12 for the byte packing below
- Q_BASE, 10000, BRAM address offset of Q sample 0
- RD_LAT, 2, BRAM read latency in clk cycles (1..3)
- HDR_EN, 1, 1 = send header 0xAA then 0x55 before the samples

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_over  in  1  level: all samples written to BRAM
- ram_addr_a  out  ADDR_W  port A read address (I)
- ram_addr_b  out  ADDR_W  port B read address (Q)
- ram_en  out  1  BRAM read enable; wea is driven 0 elsewhere
- ram_rd_data_a  in  DATA_W  port A read data
- ram_rd_data_b  in  DATA_W  port B read data
- tx_byte  out  8  byte to transmit
- tx_valid  out  1  tx_byte valid
- tx_ready  in  1  UART engine accepts the byte
- dump_busy  out  1  high from start until DONE is entered
- dump_done  out  1  one-cycle pulse when the last byte is accepted
- sample_cnt  out  ADDR_W  index of the pair currently being sent

Behaviour:
- Reset: the clock is clk; reset is rst_n, asynchronous and active-low. All outputs reset to 0, and the FSM resets to IDLE. Reset asserted mid-dump aborts the dump immediately; no partial resume.
- Start: on the rising edge of wr_over (wr_over registered once; start = wr_over & ~wr_over_d) while in IDLE. A level held high across reset release counts as a rising edge on the first sampled cycle.
- FSM states: IDLE, HDR, RD, RD_WAIT, SEND, NEXT, DONE.
  - IDLE -> HDR if HDR_EN, else -> RD.
  - HDR: present 0xAA, then 0x55. Advance only on a transfer, then -> RD.
  - RD: ram_en=1 for one cycle, ram_addr_a=sample_cnt, ram_addr_b=Q_BASE+sample_cnt (ADDR_W wrap, no saturation) -> RD_WAIT.
  - RD_WAIT: count RD_LAT cycles after the ram_en cycle, capture both data words in the last cycle -> SEND.
  - SEND: byte0={I[11:4]}, byte1={I[3:0],Q[11:8]}, byte2={Q[7:0]}.
  - NEXT: if sample_cnt==SAMPLE_NUM-1 -> DONE with a dump_done pulse; else sample_cnt+1 -> RD.
  - DONE: hold until wr_over is low, then -> IDLE with sample_cnt cleared (re-arm).
- Byte handshake:
  - A transfer occurs on a clk edge with tx_valid & tx_ready.
  - tx_byte is stable while tx_valid=1 and ready=0.
  - On a transfer, the next byte of the same group loads on that same edge, with valid staying high (back-to-back allowed).
  - After byte2 (or 0x55), tx_valid drops.
  - tx_ready high while tx_valid is low has no effect.
- Throughput: per pair, 1 (RD) + RD_LAT + 3 bytes + 1 (NEXT) cycles minimum with tx_ready tied high.
- dump_busy=1 in all states except IDLE and DONE.
- ram_en=0 outside RD and the RD_WAIT capture window.
- Addresses hold their last value otherwise.
- A wr_over deassert mid-dump is ignored; the dump completes.

Test Plan:
- SAMPLE_NUM=4, HDR_EN=1, tx_ready=1, BRAM model I[n]=0x100+n, Q[n]=0xA50+n, wr_over 0->1 -> bytes AA 55 10 0A 50 10 1A 51 10 2A 52 10 3A 53, dump_done pulse once after the last byte, addresses B = 10000..10003.
- Same setup, tx_ready toggling 1-of-3 cycles randomly -> identical byte stream, tx_byte never changes while valid & ~ready.
- RD_LAT=1 and RD_LAT=3 with I=0xFFF, Q=0x000 -> bytes FF F0 00 for each pair, capture at the correct cycle (mismatch if off by one).
- rst_n low after 5 bytes, then wr_over re-pulsed -> restart from header and pair 0, no stale byte emitted.
- Dump done, wr_over held high -> no restart; wr_over low then high -> second full dump, sample_cnt restarts at 0.
- Full SAMPLE_NUM=10000, tx_ready=1 -> 30002 bytes, last pair read at addresses 9999/19999, dump_busy low after the dump_done cycle.

Source files
------------

// File: rtl/qpsk_uart_dump_ctrl_if.sv
// BRAM read port pair and UART byte handshake between the dump controller
// (master) and the memory / transmitter side (slave).
interface qpsk_uart_dump_ctrl_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 12
);
    logic [ADDR_W-1:0] ram_addr_a;
    logic [ADDR_W-1:0] ram_addr_b;
    logic              ram_en;
    logic [DATA_W-1:0] ram_rd_data_a;
    logic [DATA_W-1:0] ram_rd_data_b;
    logic [7:0]        tx_byte;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output ram_addr_a, ram_addr_b, ram_en, tx_byte, tx_valid,
        input  ram_rd_data_a, ram_rd_data_b, tx_ready
    );

    modport slave (
        input  ram_addr_a, ram_addr_b, ram_en, tx_byte, tx_valid,
        output ram_rd_data_a, ram_rd_data_b, tx_ready
    );
endinterface

// File: rtl/qpsk_uart_dump_ctrl.sv
// Reads corrected I/Q pairs back from the output BRAM after the write phase and
// streams them as 3-byte groups (optionally after an AA 55 header) to the UART.
module qpsk_uart_dump_ctrl #(
    parameter int SAMPLE_NUM = 10000,
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 12,
    parameter int Q_BASE     = 10000,
    parameter int RD_LAT     = 2,
    parameter int HDR_EN     = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_over,
    qpsk_uart_dump_ctrl_if.master    bus,
    output logic                     dump_busy,
    output logic                     dump_done,
    output logic [ADDR_W-1:0]        sample_cnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR     = 3'd1,
        S_RD      = 3'd2,
        S_RD_WAIT = 3'd3,
        S_SEND    = 3'd4,
        S_NEXT    = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SAMPLE_NUM - 1);
    localparam logic [ADDR_W-1:0] Q_OFS    = ADDR_W'(Q_BASE);
    localparam logic [1:0]        LAT      = 2'(RD_LAT);
    localparam logic [7:0]        HDR0     = 8'hAA;
    localparam logic [7:0]        HDR1     = 8'h55;

    state_t            state_q, state_d;
    logic              wr_over_q;
    logic [1:0]        byte_sel_q, byte_sel_d;
    logic [1:0]        wait_q, wait_d;
    logic [3:0]        i_lo_q, i_lo_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              tx_valid_q, tx_valid_d;
    logic              ram_en_q, ram_en_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d;
    logic [ADDR_W-1:0] addr_b_q, addr_b_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              start_s;
    logic              xfer_s;
    logic              go_rd_s;
    logic [ADDR_W-1:0] rd_idx_s;

    // State and all registered outputs; reset aborts any dump in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_over_q  <= 1'b0;
            byte_sel_q <= 2'd0;
            wait_q     <= 2'd0;
            i_lo_q     <= 4'd0;
            q_q        <= '0;
            tx_byte_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            ram_en_q   <= 1'b0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_over_q  <= wr_over;
            byte_sel_q <= byte_sel_d;
            wait_q     <= wait_d;
            i_lo_q     <= i_lo_d;
            q_q        <= q_d;
            tx_byte_q  <= tx_byte_d;
            tx_valid_q <= tx_valid_d;
            ram_en_q   <= ram_en_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state and next-output logic; the next byte loads on the accepting edge.
    always_comb begin
        state_d    = state_q;
        byte_sel_d = byte_sel_q;
        wait_d     = wait_q;
        i_lo_d     = i_lo_q;
        q_d        = q_q;
        tx_byte_d  = tx_byte_q;
        tx_valid_d = tx_valid_q;
        ram_en_d   = 1'b0;
        addr_a_d   = addr_a_q;
        addr_b_d   = addr_b_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        go_rd_s    = 1'b0;
        rd_idx_s   = cnt_q;
        start_s    = wr_over & ~wr_over_q;
        xfer_s     = tx_valid_q & bus.tx_ready;

        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    if (HDR_EN != 0) begin
                        state_d    = S_HDR;
                        tx_byte_d  = HDR0;
                        tx_valid_d = 1'b1;
                        byte_sel_d = 2'd0;
                    end else begin
                        state_d = S_RD;
                        go_rd_s = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HDR: begin
                if (xfer_s) begin
                    if (byte_sel_q == 2'd0) begin
                        tx_byte_d  = HDR1;
                        byte_sel_d = 2'd1;
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = S_RD;
                        go_rd_s    = 1'b1;
                    end
                end else begin
                    state_d = S_HDR;
                end
            end
            S_RD: begin
                state_d = S_RD_WAIT;
                wait_d  = 2'd1;
            end
            S_RD_WAIT: begin
                // wait_q counts cycles since the enable cycle; data is live on the last one
                if (wait_q == LAT) begin
                    i_lo_d     = bus.ram_rd_data_a[3:0];
                    q_d        = bus.ram_rd_data_b;
                    tx_byte_d  = bus.ram_rd_data_a[11:4];
                    tx_valid_d = 1'b1;
                    byte_sel_d = 2'd0;
                    state_d    = S_SEND;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            S_SEND: begin
                if (xfer_s) begin
                    case (byte_sel_q)
                        2'd0: begin
                            tx_byte_d  = {i_lo_q, q_q[11:8]};
                            byte_sel_d = 2'd1;
                        end
                        2'd1: begin
                            tx_byte_d  = q_q[7:0];
                            byte_sel_d = 2'd2;
                        end
                        default: begin
                            tx_valid_d = 1'b0;
                            state_d    = S_NEXT;
                            done_d     = (cnt_q == LAST_IDX);
                        end
                    endcase
                end else begin
                    state_d = S_SEND;
                end
            end
            S_NEXT: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    rd_idx_s = cnt_q + 1'b1;
                    state_d  = S_RD;
                    go_rd_s  = 1'b1;
                end
            end
            S_DONE: begin
                if (!wr_over) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase

        if (go_rd_s) begin
            ram_en_d = 1'b1;
            addr_a_d = rd_idx_s;
            addr_b_d = Q_OFS + rd_idx_s;
        end else begin
            ram_en_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    assign bus.ram_addr_a = addr_a_q;
    assign bus.ram_addr_b = addr_b_q;
    assign bus.ram_en     = ram_en_q;
    assign bus.tx_byte    = tx_byte_q;
    assign bus.tx_valid   = tx_valid_q;
    assign dump_busy      = busy_q;
    assign dump_done      = done_q;
    assign sample_cnt     = cnt_q;

endmodule

// File: tb/tb_qpsk_uart_dump_ctrl.sv
// Directed bench for the BRAM-to-UART dump controller: four instances cover the
// main 4-pair dump, read latencies 1 and 3, and the full 10000-pair dump.
`timescale 1ns/1ps
module tb_qpsk_uart_dump_ctrl;
    localparam int AW = 15;
    localparam logic [11:0] JUNK = 12'h5A5;

    typedef struct {
        int         run;
        int         pos;
        logic [7:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic wr_a = 1'b0, wr_l1 = 1'b0, wr_l3 = 1'b0, wr_f = 1'b0;
    logic busy_a, done_a, busy_l1, done_l1, busy_l3, done_l3, busy_f, done_f;
    logic [AW-1:0] cnt_a, cnt_l1, cnt_l3, cnt_f;

    qpsk_uart_dump_ctrl_if #(.ADDR_W(AW), .DATA_W(12)) bus_a (), bus_l1 (), bus_l3 (), bus_f ();

    qpsk_uart_dump_ctrl #(.SAMPLE_NUM(4), .RD_LAT(2), .HDR_EN(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_over(wr_a), .bus(bus_a),
        .dump_busy(busy_a), .dump_done(done_a), .sample_cnt(cnt_a));
    qpsk_uart_dump_ctrl #(.SAMPLE_NUM(2), .RD_LAT(1), .HDR_EN(0)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .wr_over(wr_l1), .bus(bus_l1),
        .dump_busy(busy_l1), .dump_done(done_l1), .sample_cnt(cnt_l1));
    qpsk_uart_dump_ctrl #(.SAMPLE_NUM(2), .RD_LAT(3), .HDR_EN(1)) dut_l3 (
        .clk(clk), .rst_n(rst_n), .wr_over(wr_l3), .bus(bus_l3),
        .dump_busy(busy_l3), .dump_done(done_l3), .sample_cnt(cnt_l3));
    qpsk_uart_dump_ctrl #(.SAMPLE_NUM(10000), .RD_LAT(1), .HDR_EN(1)) dut_f (
        .clk(clk), .rst_n(rst_n), .wr_over(wr_f), .bus(bus_f),
        .dump_busy(busy_f), .dump_done(done_f), .sample_cnt(cnt_f));

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [11:0] i_of(input logic [AW-1:0] a, input logic ones);
        if (ones) return 12'hFFF;
        return 12'h100 + a[11:0];
    endfunction

    function automatic logic [11:0] q_of(input logic [AW-1:0] a, input logic ones);
        logic [AW-1:0] d;
        d = a - 15'd10000;
        if (ones) return 12'h000;
        return 12'hA50 + d[11:0];
    endfunction

    // BRAM models: data is valid exactly RD_LAT cycles after the enable, junk otherwise
    logic [11:0] pa_a [3], pb_a [3], pa_l1 [3], pb_l1 [3], pa_l3 [3], pb_l3 [3], pa_f [3], pb_f [3];
    always @(posedge clk) begin
        pa_a[0]  <= bus_a.ram_en  ? i_of(bus_a.ram_addr_a, 1'b0)  : JUNK;
        pb_a[0]  <= bus_a.ram_en  ? q_of(bus_a.ram_addr_b, 1'b0)  : JUNK;
        pa_l1[0] <= bus_l1.ram_en ? i_of(bus_l1.ram_addr_a, 1'b1) : JUNK;
        pb_l1[0] <= bus_l1.ram_en ? q_of(bus_l1.ram_addr_b, 1'b1) : JUNK;
        pa_l3[0] <= bus_l3.ram_en ? i_of(bus_l3.ram_addr_a, 1'b1) : JUNK;
        pb_l3[0] <= bus_l3.ram_en ? q_of(bus_l3.ram_addr_b, 1'b1) : JUNK;
        pa_f[0]  <= bus_f.ram_en  ? i_of(bus_f.ram_addr_a, 1'b0)  : JUNK;
        pb_f[0]  <= bus_f.ram_en  ? q_of(bus_f.ram_addr_b, 1'b0)  : JUNK;
        for (int k = 1; k < 3; k++) begin
            pa_a[k] <= pa_a[k-1];   pb_a[k] <= pb_a[k-1];
            pa_l1[k] <= pa_l1[k-1]; pb_l1[k] <= pb_l1[k-1];
            pa_l3[k] <= pa_l3[k-1]; pb_l3[k] <= pb_l3[k-1];
            pa_f[k] <= pa_f[k-1];   pb_f[k] <= pb_f[k-1];
        end
    end
    assign bus_a.ram_rd_data_a  = pa_a[1];
    assign bus_a.ram_rd_data_b  = pb_a[1];
    assign bus_l1.ram_rd_data_a = pa_l1[0];
    assign bus_l1.ram_rd_data_b = pb_l1[0];
    assign bus_l3.ram_rd_data_a = pa_l3[2];
    assign bus_l3.ram_rd_data_b = pb_l3[2];
    assign bus_f.ram_rd_data_a  = pa_f[0];
    assign bus_f.ram_rd_data_b  = pb_f[0];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]    got  [6][$];
    int            tcyc [6][$];
    logic [AW-1:0] addrb[6][$];
    int run_a = 0;
    int dcnt_a = 0, dcnt_l1 = 0, dcnt_l3 = 0, dcnt_f = 0;
    int done_cyc_a = 0;
    logic stall_a = 1'b0;
    logic [7:0] hold_b_a = 8'd0;
    logic rand_a = 1'b0;
    int nbytes_f = 0, f_err = 0;
    logic [AW-1:0] last_a_f = '0, last_b_f = '0;

    function automatic logic [7:0] full_exp(input int p);
        int n, k;
        logic [11:0] iv, qv;
        if (p == 0) return 8'hAA;
        if (p == 1) return 8'h55;
        n = (p - 2) / 3;
        k = (p - 2) % 3;
        iv = 12'h100 + 12'(n);
        qv = 12'hA50 + 12'(n);
        case (k)
            0:       return iv[11:4];
            1:       return {iv[3:0], qv[11:8]};
            default: return qv[7:0];
        endcase
    endfunction

    // Monitors sample on the falling edge; a transfer seen here happens at the next rise
    always @(negedge clk) begin
        if (bus_a.tx_valid && bus_a.tx_ready) begin
            got[run_a].push_back(bus_a.tx_byte);
            tcyc[run_a].push_back(cyc);
        end
        if (bus_a.ram_en) addrb[run_a].push_back(bus_a.ram_addr_b);
        if (done_a) begin
            dcnt_a     <= dcnt_a + 1;
            done_cyc_a <= cyc;
        end
        if (stall_a) check("tx_hold_stable", {23'd0, bus_a.tx_valid, bus_a.tx_byte}, {23'd0, 1'b1, hold_b_a});
        stall_a  <= bus_a.tx_valid & ~bus_a.tx_ready;
        hold_b_a <= bus_a.tx_byte;

        if (bus_l1.tx_valid && bus_l1.tx_ready) got[4].push_back(bus_l1.tx_byte);
        if (bus_l3.tx_valid && bus_l3.tx_ready) got[5].push_back(bus_l3.tx_byte);
        if (done_l1) dcnt_l1 <= dcnt_l1 + 1;
        if (done_l3) dcnt_l3 <= dcnt_l3 + 1;

        if (bus_f.tx_valid && bus_f.tx_ready) begin
            if (bus_f.tx_byte !== full_exp(nbytes_f)) f_err <= f_err + 1;
            nbytes_f <= nbytes_f + 1;
        end
        if (bus_f.ram_en) begin
            last_a_f <= bus_f.ram_addr_a;
            last_b_f <= bus_f.ram_addr_b;
        end
        if (done_f) dcnt_f <= dcnt_f + 1;
    end

    // Ready driver for the main instance: always high, or high one cycle in three at random
    initial begin
        bus_a.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus_a.tx_ready = rand_a ? ($urandom_range(0, 2) == 0) : 1'b1;
        end
    end

    function automatic int cnt_of(input int w);
        case (w)
            0:       return dcnt_a;
            1:       return dcnt_l1;
            2:       return dcnt_l3;
            3:       return dcnt_f;
            4:       return got[2].size();
            default: return 0;
        endcase
    endfunction

    task automatic wait_for(input int which, input int target, input int budget, input string nm);
        int k;
        k = 0;
        while (cnt_of(which) < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(nm, cnt_of(which), target);
    endtask

    function automatic int tc(input int r, input int i);
        if (i < tcyc[r].size()) return tcyc[r][i];
        return -1000;
    endfunction

    logic [7:0] s_main [14] = '{8'hAA, 8'h55, 8'h10, 8'h0A, 8'h50, 8'h10, 8'h1A,
                                8'h51, 8'h10, 8'h2A, 8'h52, 8'h10, 8'h3A, 8'h53};
    logic [7:0] s_ff [8]    = '{8'hAA, 8'h55, 8'hFF, 8'hF0, 8'h00, 8'hFF, 8'hF0, 8'h00};
    int exp_len [6]         = '{14, 14, 5, 14, 6, 8};

    initial begin
        vec_t vt[$];
        logic [7:0] g;

        for (int p = 0; p < 14; p++) begin
            vt.push_back('{0, p, s_main[p]});
            vt.push_back('{1, p, s_main[p]});
            vt.push_back('{3, p, s_main[p]});
        end
        for (int p = 0; p < 5; p++) vt.push_back('{2, p, s_main[p]});
        for (int p = 0; p < 6; p++) vt.push_back('{4, p, s_ff[p+2]});
        for (int p = 0; p < 8; p++) vt.push_back('{5, p, s_ff[p]});
        bus_l1.tx_ready = 1'b1;
        bus_l3.tx_ready = 1'b1;
        bus_f.tx_ready  = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_tx_valid", {31'd0, bus_a.tx_valid}, 32'd0);
        check("rst_tx_byte", {24'd0, bus_a.tx_byte}, 32'd0);
        check("rst_ram_en", {31'd0, bus_a.ram_en}, 32'd0);
        check("rst_addr_b", {17'd0, bus_a.ram_addr_b}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_sample_cnt", {17'd0, cnt_a}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Run 0: 4 pairs, ready tied high
        run_a = 0;
        wr_a  = 1'b1;
        wait_for(0, 1, 400, "run0_done");
        check("run0_busy_in_done_cycle", {31'd0, busy_a}, 32'd1);
        @(negedge clk); #1;
        check("run0_busy_after_done", {31'd0, busy_a}, 32'd0);
        check("run0_cnt_in_done", {17'd0, cnt_a}, 32'd3);
        check("run0_done_after_last", 32'(done_cyc_a - tc(0, 13)), 32'd1);
        check("run0_hdr_to_pair0", 32'(tc(0, 2) - tc(0, 1)), 32'd4);
        check("run0_pair_period", 32'(tc(0, 5) - tc(0, 2)), 32'd7);
        check("run0_read_count", 32'(addrb[0].size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("run0_addr_b%0d", i),
                  (i < addrb[0].size()) ? {17'd0, addrb[0][i]} : 32'hFFFF_FFFF, 32'(10000 + i));

        // wr_over still high: no restart
        repeat (20) @(negedge clk); #1;
        check("hold_no_restart_busy", {31'd0, busy_a}, 32'd0);
        check("hold_no_restart_bytes", 32'(got[0].size()), 32'd14);
        check("hold_done_count", 32'(dcnt_a), 32'd1);
        wr_a = 1'b0;
        repeat (3) @(negedge clk); #1;
        check("rearm_cnt_cleared", {17'd0, cnt_a}, 32'd0);

        // Run 1: random back-pressure
        run_a  = 1;
        rand_a = 1'b1;
        wr_a   = 1'b1;
        wait_for(0, 2, 3000, "run1_done");
        rand_a = 1'b0;
        wr_a   = 1'b0;
        repeat (3) @(negedge clk);

        // Run 2: reset after the fifth byte is accepted
        run_a = 2;
        wr_a  = 1'b1;
        wait_for(4, 5, 200, "run2_five_bytes");
        @(posedge clk); #1;
        rst_n = 1'b0;
        wr_a  = 1'b0;
        @(negedge clk); #1;
        check("midrst_tx_valid", {31'd0, bus_a.tx_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy_a}, 32'd0);
        check("midrst_cnt", {17'd0, cnt_a}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Run 3: fresh dump after the abort
        run_a = 3;
        wr_a  = 1'b1;
        wait_for(0, 3, 400, "run3_done");

        // Read latency 1 (no header) and 3 (with header)
        wr_l1 = 1'b1;
        wr_l3 = 1'b1;
        wait_for(1, 1, 300, "lat1_done");
        wait_for(2, 1, 300, "lat3_done");

        // Full-size dump
        wr_f = 1'b1;
        wait_for(3, 1, 70000, "full_done");
        check("full_busy_in_done_cycle", {31'd0, busy_f}, 32'd1);
        @(negedge clk); #1;
        check("full_busy_after_done", {31'd0, busy_f}, 32'd0);
        check("full_byte_count", 32'(nbytes_f), 32'd30002);
        check("full_byte_errors", 32'(f_err), 32'd0);
        check("full_last_addr_a", {17'd0, last_a_f}, 32'd9999);
        check("full_last_addr_b", {17'd0, last_b_f}, 32'd19999);

        for (int r = 0; r < 6; r++)
            check($sformatf("run%0d_length", r), 32'(got[r].size()), 32'(exp_len[r]));
        for (int i = 0; i < vt.size(); i++) begin
            g = (vt[i].pos < got[vt[i].run].size()) ? got[vt[i].run][vt[i].pos] : 8'h00;
            check($sformatf("run%0d_byte%0d", vt[i].run, vt[i].pos), {24'd0, g}, {24'd0, vt[i].exp});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
